sci_bus_master: RTL and testbench

- Bus-side initiator for the `uart` SCI register interface.
- Owns `scisel`/`rw`/`addr`/`dbus` and services `sciirq`, so the rest of the design sees plain valid/ready byte streams instead of register accesses.
- After reset it writes the control register once, then polls or reads status, drains received bytes and feeds transmit bytes.

---
 rtl/sci_bus_master.sv | 178 +++++++++++++++++
 tb/tb_sci_bus_master.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sci_bus_master.sv
// Bus-side initiator for the UART SCI register interface: configures the UART, then
// moves bytes between the register bus and valid/ready streams. Option: SCI_BUS_MASTER_ERR_CNT_EN.
module sci_bus_master #(
    parameter logic [7:0] CTRL_INIT = 8'h40,
    parameter int         RD_WAIT   = 1
) (
    input  logic       clk,
    input  logic       rstb,
    output logic       scisel,
    output logic       rw,
    output logic [1:0] addr,
    inout  wire  [7:0] dbus,
    input  logic       sciirq,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [1:0] rx_err,
`ifdef SCI_BUS_MASTER_ERR_CNT_EN
    output logic [7:0] err_cnt,
`endif
    output logic       init_done
);

    // state     | meaning
    // S_BOOT    | bus idle for one cycle out of reset
    // S_CFG     | write CTRL_INIT to control register
    // S_IDLE    | bus idle; wait for irq or pending tx byte
    // S_RD_STAT | read status register (RD_WAIT cycles)
    // S_DECIDE  | bus gap; choose rx read, tx write or idle
    // S_RD_DATA | read data register into rx buffer
    // S_WR_DATA | write holding byte to data register
    typedef enum logic [2:0] {
        S_BOOT, S_CFG, S_IDLE, S_RD_STAT, S_DECIDE, S_RD_DATA, S_WR_DATA
    } state_t;

    localparam logic [1:0] RD_TC = 2'(RD_WAIT - 1);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] stat_q, stat_d;   // {TDRE, RDRF, OR, FE}
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [1:0] rx_err_q, rx_err_d;
    logic       rx_valid_q, rx_valid_d;
    logic       init_done_q, init_done_d;
    logic       drv_en;
    logic [7:0] drv_data;
`ifdef SCI_BUS_MASTER_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= S_BOOT;
            cnt_q       <= RD_TC;
            stat_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_data_q   <= '0;
            rx_err_q    <= '0;
            rx_valid_q  <= 1'b0;
            init_done_q <= 1'b0;
`ifdef SCI_BUS_MASTER_ERR_CNT_EN
            err_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stat_q      <= stat_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_err_q    <= rx_err_d;
            rx_valid_q  <= rx_valid_d;
            init_done_q <= init_done_d;
`ifdef SCI_BUS_MASTER_ERR_CNT_EN
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    assign tx_ready = init_done_q & ~hold_full_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = RD_TC;
        stat_d      = stat_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_data_d   = rx_data_q;
        rx_err_d    = rx_err_q;
        rx_valid_d  = rx_valid_q;
        init_done_d = init_done_q;
`ifdef SCI_BUS_MASTER_ERR_CNT_EN
        err_cnt_d   = err_cnt_q;
`endif
        scisel      = 1'b0;
        rw          = 1'b0;
        addr        = 2'b00;
        drv_en      = 1'b0;
        drv_data    = 8'h00;

        if (tx_valid && tx_ready) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

        case (state_q)
            S_BOOT: state_d = S_CFG;
            S_CFG: begin
                scisel      = 1'b1;
                rw          = 1'b1;
                addr        = 2'b11;
                drv_en      = 1'b1;
                drv_data    = CTRL_INIT;
                init_done_d = 1'b1;
                state_d     = S_IDLE;
            end
            S_IDLE: if (sciirq || hold_full_q) state_d = S_RD_STAT;
            S_RD_STAT: begin
                scisel = 1'b1;
                addr   = 2'b01;
                if (cnt_q == 2'd0) begin
                    stat_d  = dbus[7:4];
                    state_d = S_DECIDE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_DECIDE: begin
                // receive wins over transmit so the UART data register drains first
                if (stat_q[2] && !rx_valid_q)       state_d = S_RD_DATA;
                else if (stat_q[3] && hold_full_q)  state_d = S_WR_DATA;
                else                                state_d = S_IDLE;
            end
            S_RD_DATA: begin
                scisel = 1'b1;
                if (cnt_q == 2'd0) begin
                    rx_data_d  = dbus;
                    rx_err_d   = stat_q[1:0];
                    rx_valid_d = 1'b1;
`ifdef SCI_BUS_MASTER_ERR_CNT_EN
                    if ((stat_q[1] || stat_q[0]) && err_cnt_q != 8'hFF)
                        err_cnt_d = err_cnt_q + 8'd1;
`endif
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_WR_DATA: begin
                scisel      = 1'b1;
                rw          = 1'b1;
                drv_en      = 1'b1;
                drv_data    = hold_q;
                hold_full_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_BOOT;
        endcase
    end

    // drv_en decodes the async-reset state register, so reset releases the bus at once
    assign dbus      = drv_en ? drv_data : 8'hzz;
    assign rx_data   = rx_data_q;
    assign rx_err    = rx_err_q;
    assign rx_valid  = rx_valid_q;
    assign init_done = init_done_q;
`ifdef SCI_BUS_MASTER_ERR_CNT_EN
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_sci_bus_master.sv
// Directed bench for sci_bus_master with a behavioural UART register model in loopback.
module tb_sci_bus_master;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       scisel, rw;
    logic [1:0] addr;
    wire  [7:0] dbus;
    logic       sciirq;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic [1:0] rx_err;
    logic       init_done;
`ifdef SCI_BUS_MASTER_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int tests = 0;
    int fails = 0;

    sci_bus_master dut (
        .clk(clk), .rstb(rstb), .scisel(scisel), .rw(rw), .addr(addr), .dbus(dbus),
        .sciirq(sciirq), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_err(rx_err),
`ifdef SCI_BUS_MASTER_ERR_CNT_EN
        .err_cnt(err_cnt),
`endif
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    // UART register model: transmit loops back to receive 20 cycles after a data write
    logic       tdre_m = 1'b1, rdrf_m = 1'b0, or_m = 1'b0, fe_m = 1'b0;
    logic [7:0] rx_dr_m = 8'h00, shift_m = 8'h00;
    int         timer_m = 0;
    bit         fe_inject = 1'b0;
    bit         rd_now;
    int         data_rds = 0;
    int         bad_wr = 0;
    logic [7:0] tx_log[$];
    logic [7:0] rx_log[$];
    logic [1:0] err_log[$];

    assign sciirq = rdrf_m;
    assign dbus = (scisel && !rw) ? ((addr == 2'b01) ? {tdre_m, rdrf_m, or_m, fe_m, 4'h0} : rx_dr_m)
                                  : 8'hzz;

    always @(posedge clk) begin
        rd_now = scisel && !rw && addr == 2'b00;
        if (rd_now) begin
            rdrf_m <= 1'b0;
            or_m   <= 1'b0;
            fe_m   <= 1'b0;
            data_rds++;
        end
        if (scisel && rw && addr == 2'b00) begin
            if (!tdre_m) bad_wr++;
            tx_log.push_back(dbus);
            shift_m <= dbus;
            tdre_m  <= 1'b0;
            timer_m <= 20;
        end else if (timer_m != 0) begin
            timer_m <= timer_m - 1;
            if (timer_m == 1) begin
                tdre_m <= 1'b1;
                if (rdrf_m && !rd_now) begin
                    or_m <= 1'b1;
                end else begin
                    rdrf_m  <= 1'b1;
                    rx_dr_m <= shift_m;
                    fe_m    <= fe_inject;
                end
            end
        end
        if (rx_valid && rx_ready) begin
            rx_log.push_back(rx_data);
            err_log.push_back(rx_err);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) check_eq("tx_ready_timeout", 32'(tx_ready), 32'h1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx(input int cnt);
        int n = 0;
        while (rx_log.size() < cnt && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("rx_count", 32'(rx_log.size()), 32'(cnt));
    endtask

    task automatic wait_cfg_write();
        int n = 0;
        @(negedge clk);
        while (!scisel && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("cfg_sel", 32'(scisel), 32'h1);
        check_eq("cfg_rw", 32'(rw), 32'h1);
        check_eq("cfg_addr", 32'(addr), 32'h3);
        check_eq("cfg_dbus", 32'(dbus), 32'h40);
        check_eq("cfg_init_before", 32'(init_done), 32'h0);
        @(negedge clk);
        check_eq("cfg_gap_sel", 32'(scisel), 32'h0);
        check_eq("init_done", 32'(init_done), 32'h1);
        check_eq("tx_ready_init", 32'(tx_ready), 32'h1);
    endtask

    task automatic check_reset_outputs(input string phase);
        check_eq({phase, "_scisel"}, 32'(scisel), 32'h0);
        check_eq({phase, "_rw"}, 32'(rw), 32'h0);
        check_eq({phase, "_addr"}, 32'(addr), 32'h0);
        check_eq({phase, "_dbus"}, {24'h0, dbus}, 32'h0000_00zz);
        check_eq({phase, "_tx_ready"}, 32'(tx_ready), 32'h0);
        check_eq({phase, "_rx_valid"}, 32'(rx_valid), 32'h0);
        check_eq({phase, "_rx_data"}, 32'(rx_data), 32'h0);
        check_eq({phase, "_rx_err"}, 32'(rx_err), 32'h0);
        check_eq({phase, "_init_done"}, 32'(init_done), 32'h0);
`ifdef SCI_BUS_MASTER_ERR_CNT_EN
        check_eq({phase, "_err_cnt"}, 32'(err_cnt), 32'h0);
`endif
    endtask

    initial begin
        int n;
        #2;
        check_reset_outputs("rst");
        repeat (3) @(negedge clk);
        rstb = 1'b1;

        wait_cfg_write();

        // single loopback byte
        send_byte(8'h6B);
        wait_rx(1);
        check_eq("lb_data", 32'(rx_log[0]), 32'h6B);
        check_eq("lb_err", 32'(err_log[0]), 32'h0);
        check_eq("lb_tx", 32'(tx_log[0]), 32'h6B);
        check_eq("lb_valid_drop", 32'(rx_valid), 32'h0);

        // back-to-back transmit must wait for TDRE
        send_byte(8'h55);
        send_byte(8'hAA);
        wait_rx(3);
        check_eq("b2b_first", 32'(rx_log[1]), 32'h55);
        check_eq("b2b_second", 32'(rx_log[2]), 32'hAA);
        check_eq("b2b_no_busy_wr", 32'(bad_wr), 32'h0);

        // consumer stalls: first byte held, second not read, third overruns
        rx_ready = 1'b0;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        repeat (120) @(negedge clk);
        check_eq("hold_valid", 32'(rx_valid), 32'h1);
        check_eq("hold_data", 32'(rx_data), 32'h11);
        check_eq("hold_rd_skip", 32'(data_rds), 32'h4);
        check_eq("hold_tx_cnt", 32'(tx_log.size()), 32'h6);
        repeat (30) @(negedge clk);
        check_eq("hold_data_late", 32'(rx_data), 32'h11);
        rx_ready = 1'b1;
        wait_rx(5);
        check_eq("rel_first", 32'(rx_log[3]), 32'h11);
        check_eq("rel_first_err", 32'(err_log[3]), 32'h0);
        check_eq("rel_next", 32'(rx_log[4]), 32'h22);
        check_eq("rel_next_err", 32'(err_log[4]), 32'h2);

        // framing errors on three bytes
        fe_inject = 1'b1;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        wait_rx(8);
        fe_inject = 1'b0;
        check_eq("fe_data0", 32'(rx_log[5]), 32'h01);
        check_eq("fe_err0", 32'(err_log[5]), 32'h1);
        check_eq("fe_err1", 32'(err_log[6]), 32'h1);
        check_eq("fe_data2", 32'(rx_log[7]), 32'h03);
        check_eq("fe_err2", 32'(err_log[7]), 32'h1);
`ifdef SCI_BUS_MASTER_ERR_CNT_EN
        // one overrun earlier plus three framing errors
        check_eq("err_cnt", 32'(err_cnt), 32'h4);
`endif

        // reset in the middle of a data write
        repeat (30) @(negedge clk);
        send_byte(8'h77);
        n = 0;
        while (!(scisel && rw && addr == 2'b00) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("wr_seen", 32'(scisel && rw && addr == 2'b00), 32'h1);
        check_eq("wr_dbus", 32'(dbus), 32'h77);
        rstb = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (3) @(negedge clk);
        check_eq("abort_tx_cnt", 32'(tx_log.size()), 32'h9);
        rstb = 1'b1;
        wait_cfg_write();
        repeat (40) @(negedge clk);
        check_eq("abort_no_wr", 32'(tx_log.size()), 32'h9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
